// File: rtl/pll_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_rst_seq_pkg
// Purpose  : Shared types and constants for the PLL reset sequencer.
//            Contains the sequencer state encoding, the synchronizer depth
//            and a helper that sizes the shared phase counter.
// Revision : 1.0 - initial release
// ============================================================================
package pll_rst_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_seq_state_t;

  localparam int SYNC_STAGES = 2;

  // Bits needed for a counter that only ever reaches (max(a,b,c) - 1).
  // Clamped to 1 so a degenerate configuration still yields a legal vector.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : 1-bit level synchronizer (SYNC_STAGES flops, nominally 2).
//            Synchronous active-low reset clears every stage to 0.
// Ports    : clk   - destination clock
//            rst_n - synchronous active-low reset
//            i_d   - asynchronous level input
//            o_q   - synchronized level
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff
  import pll_rst_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Purpose  : Holds the PLL in reset, waits for lock (with timeout/retry),
//            qualifies lock stability, then releases the system reset.
//            Loss of lock in RUN re-asserts system reset and re-sequences.
// Ports    : clk        - reference clock
//            rst_n      - synchronous active-low reset
//            locked_in  - PLL locked flag (asynchronous)
//            relock_req - single-cycle request for a full re-sequence
//            pll_rst    - active-high PLL reset
//            sys_rst_n  - active-low downstream system reset
//            lock_ok    - high while in RUN
//            retry_cnt  - saturating count of lock timeouts
//            loss_cnt   - saturating count of lock losses from RUN
// Macro    : PLL_RST_SEQ_STATUS_EN - when defined, retry_cnt/loss_cnt are
//            live; otherwise both read as 0.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
  import pll_rst_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int STABLE_CYCLES = 4096,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked_in,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             lock_ok,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int            CW          = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  pll_seq_state_t r_state;
  pll_seq_state_t w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic           w_locked_s;
  logic           w_timeout;
  logic           w_loss;
  logic           r_pll_rst;
  logic           r_sys_rst_n;
  logic           r_lock_ok;

  sync_2ff u_sync_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (locked_in),
    .o_q   (w_locked_s)
  );

  // Counter-increment events; these stay valid even when relock_req
  // overrides the transition in the same cycle.
  assign w_timeout = (r_state == WAIT_LOCK) && !w_locked_s && (r_cnt == TO_LAST);
  assign w_loss    = (r_state == RUN) && !w_locked_s;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    case (r_state)
      PLL_RST: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else if (w_timeout) begin
          w_state_nxt = PLL_RST;
          w_cnt_nxt   = '0;
        end
      end
      STABLE: begin
        // A lock dropout restarts the timeout window but is not a retry.
        if (!w_locked_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        w_cnt_nxt = '0;
        if (w_loss) begin
          w_state_nxt = PLL_RST;
        end
      end
      default: begin
        w_state_nxt = PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase
    if (relock_req) begin
      w_state_nxt = PLL_RST;
      w_cnt_nxt   = '0;
    end
  end

  // Outputs decode the next state so they change on the same edge as the
  // state register, with no combinational path to the pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= PLL_RST;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_lock_ok   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pll_rst   <= (w_state_nxt == PLL_RST);
      r_sys_rst_n <= (w_state_nxt == RUN);
      r_lock_ok   <= (w_state_nxt == RUN);
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign lock_ok   = r_lock_ok;

`ifdef PLL_RST_SEQ_STATUS_EN
  localparam logic [CNT_W-1:0] STAT_MAX = '1;

  logic [CNT_W-1:0] r_retry_cnt;
  logic [CNT_W-1:0] r_loss_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
    end else begin
      if (w_timeout && (r_retry_cnt != STAT_MAX)) begin
        r_retry_cnt <= r_retry_cnt + CNT_W'(1);
      end
      if (w_loss && (r_loss_cnt != STAT_MAX)) begin
        r_loss_cnt <= r_loss_cnt + CNT_W'(1);
      end
    end
  end

  assign retry_cnt = r_retry_cnt;
  assign loss_cnt  = r_loss_cnt;
`else
  assign retry_cnt = '0;
  assign loss_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Purpose  : Directed, table-driven bench for pll_reset_sequencer with
//            RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, CNT_W=4.
//            Each step drives inputs, waits one rising edge and compares the
//            registered outputs 1 ns later ("value after edge N").
//            Status-counter expectations follow PLL_RST_SEQ_STATUS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

`ifdef PLL_RST_SEQ_STATUS_EN
  localparam bit c_STATUS = 1'b1;
`else
  localparam bit c_STATUS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked_in = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       lock_ok;
  logic [3:0] retry_cnt;
  logic [3:0] loss_cnt;

  int n_total = 0;
  int n_pass  = 0;

  pll_reset_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .CNT_W         (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .locked_in  (locked_in),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .lock_ok    (lock_ok),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   n;
    logic rst_n;
    logic lk;
    logic rq;
    logic e_pll;
    logic e_sys;
    logic e_ok;
    int   e_loss;
  } vec_t;

  vec_t vecs [17];

  function automatic logic [3:0] stat(input int x);
    return c_STATUS ? 4'(x) : 4'd0;
  endfunction

  task automatic tick(input logic r, input logic l, input logic q);
    rst_n      = r;
    locked_in  = l;
    relock_req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic ep, input logic es,
                       input logic eo, input logic [3:0] er, input logic [3:0] el);
    n_total++;
    if ({pll_rst, sys_rst_n, lock_ok, retry_cnt, loss_cnt} === {ep, es, eo, er, el}) begin
      n_pass++;
    end else begin
      $display("FAIL %s[%0d]: got pll_rst=%0b sys_rst_n=%0b lock_ok=%0b retry=%0d loss=%0d, expected pll_rst=%0b sys_rst_n=%0b lock_ok=%0b retry=%0d loss=%0d",
               name, idx, pll_rst, sys_rst_n, lock_ok, retry_cnt, loss_cnt, ep, es, eo, er, el);
    end
  endtask

  initial begin
    // Run-length records: {edges, rst_n, locked_in, relock_req, pll_rst, sys_rst_n, lock_ok, loss}
    vecs[0]  = '{3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0}; // in reset
    vecs[1]  = '{3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0}; // edges 1-3 PLL_RST
    vecs[2]  = '{7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0}; // edges 4-10 WAIT_LOCK
    vecs[3]  = '{10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0}; // lock raised at edge 10
    vecs[4]  = '{10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0}; // RUN from edge 21
    vecs[5]  = '{2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0}; // lock dropped at edge 30
    vecs[6]  = '{4,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1}; // edges 33-36 PLL_RST
    vecs[7]  = '{2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1}; // edges 37-38 WAIT_LOCK
    vecs[8]  = '{10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1}; // relock, qualify
    vecs[9]  = '{4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1}; // RUN from edge 49
    vecs[10] = '{1,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1}; // relock_req in RUN
    vecs[11] = '{3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[12] = '{3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1}; // WAIT 57, STABLE 58
    vecs[13] = '{3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1}; // 3-cycle dropout in STABLE
    vecs[14] = '{10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1}; // full requalification
    vecs[15] = '{3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1}; // RUN from edge 73
    vecs[16] = '{2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1}; // lock dropped at edge 75

    for (int v = 0; v < 17; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        tick(vecs[v].rst_n, vecs[v].lk, vecs[v].rq);
        check("vec", v, vecs[v].e_pll, vecs[v].e_sys, vecs[v].e_ok, 4'd0, stat(vecs[v].e_loss));
      end
    end

    // Lock never returns: 4 cycles of pll_rst every 24, retry_cnt saturating.
    // At the start of period 5 the timeout coincides with relock_req.
    for (int p = 0; p < 18; p++) begin
      for (int i = 0; i < 24; i++) begin
        tick(1'b1, 1'b0, (p == 5) && (i == 0));
        check("timeout", p * 24 + i, (i < 4), 1'b0, 1'b0, stat((p < 15) ? p : 15), stat(2));
      end
    end

    // Reset mid-operation, then a fresh PLL reset pulse.
    tick(1'b0, 1'b0, 1'b0);
    check("rst_mid", 0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      check("rst_rel", k, (k < 4), 1'b0, 1'b0, 4'd0, 4'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
